rgmii_rx_frame_arbiter: RTL

Shares one switch-fabric ingress bus between NUM_PORTS RGMII receive byte streams. Each stream is the 9-bit packaged format: bit 8 is the first-byte flag, bits 7:0 are data. Grants are round-robin and made only at frame boundaries, so a granted frame passes through contiguously up to its last byte. Stalled or malformed frames are aborted, and stray mid-frame bytes on ungranted ports are discarded.

---
 rtl/rgmii_rx_frame_arbiter_if.sv | 38 +++
 rtl/rgmii_rx_frame_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rgmii_rx_frame_arbiter_if.sv
//==============================================================================
// Module  : rgmii_rx_frame_arbiter_if
// Purpose : Per-port RGMII byte streams in, one arbitrated fabric stream out.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface rgmii_rx_frame_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
);
  logic [9*NUM_PORTS-1:0] port_data;
  logic [NUM_PORTS-1:0]   port_valid;
  logic [NUM_PORTS-1:0]   port_last;
  logic [NUM_PORTS-1:0]   port_ready;
  logic [8:0]             arbitrated_data;
  logic                   arbitrated_valid;
  logic                   arbitrated_last;
  logic                   arbitrated_ready;
  logic [PORT_W-1:0]      arbitrated_port;
  logic                   frame_aborted;
  logic                   orphan_dropped;

  // The master side owns the receive ports and the downstream sink.
  modport master (
    output port_data, port_valid, port_last, arbitrated_ready,
    input  port_ready, arbitrated_data, arbitrated_valid, arbitrated_last,
    input  arbitrated_port, frame_aborted, orphan_dropped
  );

  modport slave (
    input  port_data, port_valid, port_last, arbitrated_ready,
    output port_ready, arbitrated_data, arbitrated_valid, arbitrated_last,
    output arbitrated_port, frame_aborted, orphan_dropped
  );
endinterface

`default_nettype wire

// File: rtl/rgmii_rx_frame_arbiter.sv
//==============================================================================
// Module  : rgmii_rx_frame_arbiter
// Purpose : Round-robin, frame-boundary arbiter of RGMII RX streams onto one bus.
// Revision: 1.0
//==============================================================================
`default_nettype none

module rgmii_rx_frame_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input wire logic                 clock,
  input wire logic                 reset_n,
  rgmii_rx_frame_arbiter_if.slave  bus
);
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_TRANSFER = 1'b1
  } state_t;

  state_t              state, state_nx;
  logic [PORT_W-1:0]   grant, grant_nx;
  logic [PORT_W-1:0]   last_grant, last_grant_nx;
  logic [15:0]         idle_cnt, idle_cnt_nx;
  logic                first_done, first_done_nx;
  logic                aborted_q, aborted_nx;
  logic                orphan_q, orphan_nx;

  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] orphan;
  logic [NUM_PORTS-1:0] ready_c;
  logic [NUM_PORTS-1:0] sel_onehot;
  logic [8:0]           sel_data;
  logic                 sel_valid;
  logic                 sel_last;
  logic [PORT_W-1:0]    pick;
  logic                 xfer;
  logic                 restart;
  logic                 bad_first;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign eligible[i] = bus.port_valid[i] &  bus.port_data[9*i+8];
    assign orphan[i]   = bus.port_valid[i] & ~bus.port_data[9*i+8];
  end

  // Two-pass priority: first eligible above last_grant, otherwise wrap to lowest.
  always_comb begin
    logic             found_hi, found_any;
    logic [PORT_W-1:0] pick_hi, pick_any;
    found_hi  = 1'b0;
    found_any = 1'b0;
    pick_hi   = '0;
    pick_any  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (eligible[i] && !found_any) begin
        found_any = 1'b1;
        pick_any  = PORT_W'(i);
      end
      if (eligible[i] && (PORT_W'(i) > last_grant) && !found_hi) begin
        found_hi = 1'b1;
        pick_hi  = PORT_W'(i);
      end
    end
    pick = found_hi ? pick_hi : pick_any;
  end

  always_comb begin
    sel_data   = '0;
    sel_valid  = 1'b0;
    sel_last   = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant == PORT_W'(i)) begin
        sel_data      = bus.port_data[9*i +: 9];
        sel_valid     = bus.port_valid[i];
        sel_last      = bus.port_last[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    last_grant_nx = last_grant;
    idle_cnt_nx   = idle_cnt;
    first_done_nx = first_done;
    aborted_nx    = 1'b0;
    orphan_nx     = 1'b0;
    ready_c       = '0;
    xfer          = 1'b0;
    restart       = 1'b0;
    bad_first     = 1'b0;
    bus.arbitrated_data  = '0;
    bus.arbitrated_valid = 1'b0;
    bus.arbitrated_last  = 1'b0;

    case (state)
      S_IDLE: begin
        ready_c       = orphan;
        orphan_nx     = |orphan;
        idle_cnt_nx   = '0;
        first_done_nx = 1'b0;
        if (|eligible) begin
          grant_nx = pick;
          state_nx = S_TRANSFER;
        end
      end

      S_TRANSFER: begin
        // A new first byte mid-frame, or a non-first byte opening the frame, is held back.
        restart   = sel_valid &  sel_data[8] &  first_done;
        bad_first = sel_valid & ~sel_data[8] & ~first_done;
        if (restart || bad_first) begin
          aborted_nx    = 1'b1;
          last_grant_nx = grant;
          idle_cnt_nx   = '0;
          state_nx      = S_IDLE;
        end else begin
          bus.arbitrated_data  = sel_data;
          bus.arbitrated_valid = sel_valid;
          bus.arbitrated_last  = sel_last;
          ready_c              = sel_onehot & {NUM_PORTS{bus.arbitrated_ready}};
          xfer                 = sel_valid & bus.arbitrated_ready;
          if (xfer) first_done_nx = 1'b1;
          if (sel_valid)                 idle_cnt_nx = '0;
          else if (idle_cnt != 16'hFFFF) idle_cnt_nx = idle_cnt + 16'd1;
          if (xfer && sel_last) begin
            last_grant_nx = grant;
            idle_cnt_nx   = '0;
            state_nx      = S_IDLE;
          end else if (idle_cnt == TIMEOUT_VAL) begin
            aborted_nx    = 1'b1;
            last_grant_nx = grant;
            idle_cnt_nx   = '0;
            state_nx      = S_IDLE;
          end
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= PORT_W'(NUM_PORTS - 1);
      idle_cnt   <= '0;
      first_done <= 1'b0;
      aborted_q  <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      last_grant <= last_grant_nx;
      idle_cnt   <= idle_cnt_nx;
      first_done <= first_done_nx;
      aborted_q  <= aborted_nx;
      orphan_q   <= orphan_nx;
    end
  end

  // Orphan-drop ready is combinational from inputs, so it needs explicit gating in reset.
  assign bus.port_ready      = ready_c & {NUM_PORTS{reset_n}};
  assign bus.arbitrated_port = grant;
  assign bus.frame_aborted   = aborted_q;
  assign bus.orphan_dropped  = orphan_q;

endmodule

`default_nettype wire
